clock_div_prog: RTL

Multi-channel programmable clock/strobe divider. It generalises the fixed-divisor divider into NUM_CH independent channels, each with a run-time divisor and high time. New settings load glitch-free at period boundaries, and a common sync re-aligns phase across channels. Outputs drive ASIC test clocks, reset/strobe pulses and the period ticks used by the readout logic.

---
 rtl/clock_div_prog.sv | 90 +++++++++
 1 files changed

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock/strobe divider with glitch-free setting
// updates at period boundaries and a common phase-realignment sync.
module clock_div_prog #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 28,
  parameter int DEFAULT_DIV  = 2,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] divisor_in,
  input  logic [NUM_CH*CNT_W-1:0] high_in,
  output logic [NUM_CH-1:0]       clock_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] sdiv_q;
    logic [CNT_W-1:0] shigh_q;
    logic             pend_q;
    logic             co_q;
    logic             tick_q;
    logic [CNT_W-1:0] div_new;
    logic [CNT_W-1:0] high_new;
    logic             run;
    logic             eop;
    logic             apply;

    assign div_new  = divisor_in[i*CNT_W +: CNT_W];
    assign high_new = high_in[i*CNT_W +: CNT_W];

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
      run   = enable[i] && (div_q != '0);
      // >= rather than == keeps the counter from ever wrapping after a shrink.
      eop   = run && (cnt_q >= div_q - CNT_W'(1));
      apply = eop || sync || !enable[i] || (div_q == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only; all registers,
    // shadows included, are cleared by the asynchronous reset.
    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        div_q   <= CNT_W'(DEFAULT_DIV);
        high_q  <= CNT_W'(DEFAULT_HIGH);
        sdiv_q  <= '0;
        shigh_q <= '0;
        pend_q  <= 1'b0;
        co_q    <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        if (load[i] && apply) begin
          div_q  <= div_new;
          high_q <= high_new;
          pend_q <= 1'b0;
        end else if (load[i]) begin
          sdiv_q  <= div_new;
          shigh_q <= high_new;
          pend_q  <= 1'b1;
        end else if (apply) begin
          if (pend_q) begin
            div_q  <= sdiv_q;
            high_q <= shigh_q;
          end
          pend_q <= 1'b0;
        end

        if (!run || sync || eop) cnt_q <= '0;
        else                     cnt_q <= cnt_q + CNT_W'(1);

        // Outputs follow the pre-edge counter and active high time.
        co_q   <= run && (cnt_q < high_q);
        tick_q <= run && (cnt_q == '0);
      end
    end

    assign clock_out[i] = co_q;
    assign tick[i]      = tick_q;
    assign pending[i]   = pend_q;
  end

endmodule
